point_stream_driver: RTL and testbench
======================================

Name: point_stream_driver

Overview:
- Transmit/collect end of the 6-point geometry interface. Produces `give_valid`/`dataX`/`dataY` toward the point-sorting core and captures the core's `ansX`/`ansY` stream qualified by `out_valid`.
- Points are preloaded through a write port. Captured results are read back through an address port.
- Used as the on-chip source/sink for the sorter and as bench infrastructure.

Parameters:
- LENGTH, 6, points per frame (send count and capture count).
- TIMEOUT, 255, max consecutive cycles in COLLECT without `out_valid` before abort; range 1..255.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- clear  in  1  in IDLE: load_count <= 0 (buffer contents kept)
- load_valid  in  1  write load_x/load_y into point buffer
- load_x  in  8  point X to load
- load_y  in  8  point Y to load
- load_count  out  3  number of points loaded, 0..LENGTH
- start  in  1  begin frame transfer
- give_valid  out  1  point valid toward core
- dataX  out  8  point X toward core
- dataY  out  8  point Y toward core
- out_valid  in  1  result valid from core
- ansX  in  8  result X from core
- ansY  in  8  result Y from core
- rd_addr  in  3  result buffer read index
- rd_x  out  8  result X at rd_addr (combinational)
- rd_y  out  8  result Y at rd_addr (combinational)
- busy  out  1  high in SEND and COLLECT
- done  out  1  one-cycle pulse, frame fully captured
- timeout  out  1  sticky abort flag

Behaviour:
- Reset (sync, active-high, overrides all):
  - state=IDLE; load_count=0; give_valid=0; dataX=dataY=0; busy=0; done=0; timeout=0.
  - Point and result buffers cleared to 0; internal index and timer = 0.
  - Reset asserted mid-SEND or mid-COLLECT aborts immediately, with no done and no timeout.
- All outputs except rd_x/rd_y are registered.
- IDLE:
  - Precedence within one cycle: clear > start > load.
  - clear=1: load_count <= 0.
  - load_valid=1 and load_count<LENGTH: buf[load_count] <= {load_x, load_y}; load_count++.
  - load_valid=1 and load_count==LENGTH: ignored, no wrap.
  - start=1 with load_count==LENGTH: timeout <= 0; idx <= 0; go to SEND.
  - start=1 with load_count<LENGTH: ignored, state stays IDLE, no flag change.
- SEND:
  - Exactly LENGTH consecutive cycles of give_valid=1, with dataX/dataY = buf[0]..buf[LENGTH-1] in order.
  - First valid point appears in the cycle after start is sampled. There are no gaps and no backpressure.
  - After the last point: give_valid=0, dataX=dataY=0, idx=0, timer=0, go to COLLECT.
  - out_valid, start, load_valid and clear are ignored in SEND.
- COLLECT:
  - Each cycle with out_valid=1: res[idx] <= {ansX, ansY}; idx++; timer <= 0.
  - Non-consecutive out_valid beats are accepted.
  - Each cycle with out_valid=0: timer++.
  - When the LENGTH-th beat is captured: go to DONE.
  - When timer reaches TIMEOUT with fewer than LENGTH beats captured: timeout <= 1; go to IDLE; done stays 0. Partially captured results remain readable.
  - If the last beat and the timeout threshold land in the same cycle, the capture wins (the beat resets the timer).
  - start, load_valid and clear are ignored in COLLECT.
- DONE:
  - One cycle with done=1, then IDLE.
  - Point buffer and load_count are retained, so a new start resends the same frame.
  - A start sampled in the DONE cycle is ignored.
- busy is high exactly while the state is SEND or COLLECT.
- Widths: all data is 8-bit unsigned pass-through with no arithmetic. idx is 3 bits and timer is 8 bits; neither ever wraps, because both are bounded by the transitions above.
- rd_addr >= LENGTH: rd_x=rd_y=0.

Test Plan:
- **Load and send:** reset; load (10,20),(30,5),(7,7),(0,40),(25,25),(15,1); start → give_valid high for 6 consecutive cycles starting 1 cycle after start, with the data in load order; then give_valid=0, data=0, busy=1.
- **Capture and readback:** after the send, drive out_valid for 6 beats with ans=(1,1)..(6,6), including a 3-cycle gap after beat 2 → done pulses once 1 cycle after beat 6; busy drops; rd_addr 0..5 returns (1,1)..(6,6); rd_addr=6 returns (0,0).
- **Guard conditions:** load 4 points, then start → stays IDLE, give_valid never asserts, load_count=4. Load 3 more → load_count=6; the 7th point is ignored and buf[5] holds the 6th point.
- **Timeout:** TIMEOUT=8; send the frame; return 2 out_valid beats, then hold low → timeout=1 on the 8th idle cycle after beat 2; state IDLE; done never pulses; rd_addr 0,1 return the captured data. A following start clears timeout and resends.
- **Reset mid-frame:** assert reset on the 3rd give_valid cycle → next cycle give_valid=0, load_count=0, busy=0, rd_x/rd_y=0 for all addresses.
- **clear and resend:** after done, assert clear → load_count=0. Without clear, start again → the same 6 points are resent unchanged.

Source files
------------

// File: rtl/point_stream_driver_if.sv
// Point stream between the driver and the sorting core: outbound points, inbound results.
interface point_stream_driver_if;
  logic       give_valid;
  logic [7:0] dataX;
  logic [7:0] dataY;
  logic       out_valid;
  logic [7:0] ansX;
  logic [7:0] ansY;

  modport master (
    output give_valid, dataX, dataY,
    input  out_valid, ansX, ansY
  );

  modport slave (
    input  give_valid, dataX, dataY,
    output out_valid, ansX, ansY
  );
endinterface

// File: rtl/point_stream_driver.sv
// Source/sink for the point-sorting core: preloaded frame is streamed out, results
// are captured into a readable buffer, with an abort if the core goes quiet.
module point_stream_driver #(
  parameter int LENGTH  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load_valid,
  input  logic [7:0]            load_x,
  input  logic [7:0]            load_y,
  output logic [2:0]            load_count,
  input  logic                  start,
  point_stream_driver_if.master stream,
  input  logic [2:0]            rd_addr,
  output logic [7:0]            rd_x,
  output logic [7:0]            rd_y,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam logic [2:0] LEN      = 3'(LENGTH);
  localparam logic [2:0] LAST     = 3'(LENGTH - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_COLLECT, S_DONE} state_t;

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [2:0] load_count_n;
  logic [7:0] timer, timer_n;
  logic       give_valid, give_valid_n;
  logic [7:0] data_x, data_x_n;
  logic [7:0] data_y, data_y_n;
  logic       busy_n, done_n, timeout_n;
  logic       pt_we, res_we;

  logic [7:0] pt_x  [LENGTH];
  logic [7:0] pt_y  [LENGTH];
  logic [7:0] res_x [LENGTH];
  logic [7:0] res_y [LENGTH];

  // The first point is issued on the start edge itself, so idx already points at
  // the second one when SEND is entered.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    timer_n      = timer;
    load_count_n = load_count;
    give_valid_n = 1'b0;
    data_x_n     = 8'd0;
    data_y_n     = 8'd0;
    done_n       = 1'b0;
    timeout_n    = timeout;
    pt_we        = 1'b0;
    res_we       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (clear) begin
          load_count_n = 3'd0;
        end else if (start) begin
          if (load_count == LEN) begin
            timeout_n    = 1'b0;
            idx_n        = 3'd1;
            give_valid_n = 1'b1;
            data_x_n     = pt_x[0];
            data_y_n     = pt_y[0];
            state_n      = S_SEND;
          end
        end else if (load_valid && (load_count != LEN)) begin
          pt_we        = 1'b1;
          load_count_n = load_count + 3'd1;
        end
      end

      S_SEND: begin
        if (idx == LEN) begin
          idx_n   = 3'd0;
          timer_n = 8'd0;
          state_n = S_COLLECT;
        end else begin
          give_valid_n = 1'b1;
          data_x_n     = pt_x[idx];
          data_y_n     = pt_y[idx];
          idx_n        = idx + 3'd1;
        end
      end

      // A beat always resets the timer, so it wins over a coinciding timeout.
      S_COLLECT: begin
        if (stream.out_valid) begin
          res_we  = 1'b1;
          idx_n   = idx + 3'd1;
          timer_n = 8'd0;
          if (idx == LAST) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end
        end else begin
          timer_n = timer + 8'd1;
          if (timer == TMO_LAST) begin
            timeout_n = 1'b1;
            state_n   = S_IDLE;
          end
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n == S_SEND) || (state_n == S_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      timer      <= 8'd0;
      load_count <= 3'd0;
      give_valid <= 1'b0;
      data_x     <= 8'd0;
      data_y     <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      timer      <= timer_n;
      load_count <= load_count_n;
      give_valid <= give_valid_n;
      data_x     <= data_x_n;
      data_y     <= data_y_n;
      busy       <= busy_n;
      done       <= done_n;
      timeout    <= timeout_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LENGTH; i++) begin
        pt_x[i]  <= 8'd0;
        pt_y[i]  <= 8'd0;
        res_x[i] <= 8'd0;
        res_y[i] <= 8'd0;
      end
    end else begin
      if (pt_we) begin
        pt_x[load_count] <= load_x;
        pt_y[load_count] <= load_y;
      end
      if (res_we) begin
        res_x[idx] <= stream.ansX;
        res_y[idx] <= stream.ansY;
      end
    end
  end

  always_comb begin
    rd_x = 8'd0;
    rd_y = 8'd0;
    if (rd_addr < LEN) begin
      rd_x = res_x[rd_addr];
      rd_y = res_y[rd_addr];
    end
  end

  assign stream.give_valid = give_valid;
  assign stream.dataX      = data_x;
  assign stream.dataY      = data_y;

endmodule

// File: tb/tb_point_stream_driver.sv
// Directed-plus-random bench for point_stream_driver; expectations come from a
// frame-level model (loaded points, captured beats, idle-cycle count).
module tb_point_stream_driver;
  localparam int LENGTH  = 6;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset, clear, load_valid, start;
  logic [7:0] load_x, load_y;
  logic [2:0] load_count, rd_addr;
  logic [7:0] rd_x, rd_y;
  logic       busy, done, timeout;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_px [LENGTH];
  logic [7:0] m_py [LENGTH];
  logic [7:0] m_rx [LENGTH];
  logic [7:0] m_ry [LENGTH];
  int         m_count, m_beats, m_idle;
  logic       m_timeout;

  point_stream_driver_if stream ();

  point_stream_driver #(.LENGTH(LENGTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .load_valid (load_valid),
    .load_x     (load_x),
    .load_y     (load_y),
    .load_count (load_count),
    .start      (start),
    .stream     (stream),
    .rd_addr    (rd_addr),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [7:0] lx, input logic [7:0] ly,
                               input logic st, input logic cl, input logic ov,
                               input logic [7:0] ax, input logic [7:0] ay);
    load_valid       = lv;
    load_x           = lx;
    load_y           = ly;
    start            = st;
    clear            = cl;
    stream.out_valid = ov;
    stream.ansX      = ax;
    stream.ansY      = ay;
    tick();
    load_valid       = 1'b0;
    start            = 1'b0;
    clear            = 1'b0;
    stream.out_valid = 1'b0;
  endtask

  task automatic modelReset();
    m_count   = 0;
    m_beats   = 0;
    m_idle    = 0;
    m_timeout = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      m_px[i] = 8'd0; m_py[i] = 8'd0; m_rx[i] = 8'd0; m_ry[i] = 8'd0;
    end
  endtask

  task automatic loadPoint(input logic [7:0] x, input logic [7:0] y);
    applyStimulus(1'b1, x, y, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    if (m_count < LENGTH) begin
      m_px[m_count] = x;
      m_py[m_count] = y;
      m_count++;
    end
    checkOutput("load_count", load_count, m_count);
  endtask

  // Inputs other than start are randomised during SEND; all of them must be ignored.
  task automatic sendFrame();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    m_timeout = 1'b0;
    m_beats   = 0;
    m_idle    = 0;
    for (int i = 0; i < LENGTH; i++) begin
      checkOutput("send_valid", stream.give_valid, 1);
      checkOutput("send_x", stream.dataX, m_px[i]);
      checkOutput("send_y", stream.dataY, m_py[i]);
      checkOutput("send_busy", busy, 1);
      checkOutput("send_timeout", timeout, 0);
      applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    end
    checkOutput("post_send_valid", stream.give_valid, 0);
    checkOutput("post_send_x", stream.dataX, 0);
    checkOutput("post_send_y", stream.dataY, 0);
    checkOutput("post_send_busy", busy, 1);
    checkOutput("post_send_count", load_count, m_count);
  endtask

  task automatic beat(input logic [7:0] x, input logic [7:0] y);
    applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                  1'($urandom), 1'b1, x, y);
    m_rx[m_beats] = x;
    m_ry[m_beats] = y;
    m_beats++;
    m_idle = 0;
    checkOutput("beat_done", done, m_beats == LENGTH);
    checkOutput("beat_busy", busy, m_beats < LENGTH);
    checkOutput("beat_timeout", timeout, 0);
    checkOutput("beat_count", load_count, m_count);
  endtask

  task automatic idleTick();
    applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                  1'($urandom), 1'b0, 8'($urandom), 8'($urandom));
    m_idle++;
    if (m_idle >= TIMEOUT) m_timeout = 1'b1;
    checkOutput("idle_timeout", timeout, m_timeout);
    checkOutput("idle_busy", busy, !m_timeout);
    checkOutput("idle_done", done, 0);
  endtask

  task automatic finishDone();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    checkOutput("after_done_pulse", done, 0);
    checkOutput("after_done_busy", busy, 0);
    tick();
    checkOutput("done_start_ignored", stream.give_valid, 0);
    checkOutput("done_start_busy", busy, 0);
  endtask

  task automatic randomBeats();
    for (int i = 0; i < LENGTH; i++) begin
      int gap;
      gap = int'($urandom_range(4, 0));
      for (int g = 0; g < gap; g++) idleTick();
      beat(8'($urandom), 8'($urandom));
    end
  endtask

  task automatic checkReadback(input string tag);
    for (int a = 0; a < 8; a++) begin
      logic [7:0] ex, ey;
      rd_addr = 3'(a);
      #1;
      ex = 8'd0;
      ey = 8'd0;
      if (a < LENGTH) begin
        ex = m_rx[a];
        ey = m_ry[a];
      end
      checkOutput({tag, "_x"}, rd_x, ex);
      checkOutput({tag, "_y"}, rd_y, ey);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load_valid = 1'b0; start = 1'b0;
    load_x = 8'd0; load_y = 8'd0; rd_addr = 3'd0;
    stream.out_valid = 1'b0; stream.ansX = 8'd0; stream.ansY = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    modelReset();

    checkOutput("reset_count", load_count, 0);
    checkOutput("reset_valid", stream.give_valid, 0);
    checkOutput("reset_x", stream.dataX, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_timeout", timeout, 0);
    checkReadback("reset_rd");

    // Directed frame from the plan, with a 3-cycle gap and a last beat landing on
    // the cycle that would otherwise hit the timeout threshold.
    loadPoint(8'd10, 8'd20); loadPoint(8'd30, 8'd5);  loadPoint(8'd7, 8'd7);
    loadPoint(8'd0, 8'd40);  loadPoint(8'd25, 8'd25); loadPoint(8'd15, 8'd1);
    sendFrame();
    beat(8'd1, 8'd1); beat(8'd2, 8'd2);
    for (int g = 0; g < 3; g++) idleTick();
    beat(8'd3, 8'd3); beat(8'd4, 8'd4); beat(8'd5, 8'd5);
    for (int g = 0; g < TIMEOUT - 1; g++) idleTick();
    beat(8'd6, 8'd6);
    finishDone();
    checkReadback("frame1_rd");

    sendFrame();
    randomBeats();
    finishDone();
    checkReadback("resend_rd");

    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    m_count = 0;
    checkOutput("clear_count", load_count, 0);

    // Partial frame: start must be ignored until the buffer is full.
    for (int i = 0; i < 4; i++) loadPoint(8'($urandom), 8'($urandom));
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    checkOutput("short_start_valid", stream.give_valid, 0);
    checkOutput("short_start_busy", busy, 0);
    tick();
    checkOutput("short_start_valid2", stream.give_valid, 0);
    checkOutput("short_start_count", load_count, 4);
    for (int i = 0; i < 3; i++) loadPoint(8'($urandom), 8'($urandom));
    checkReadback("guard_rd");

    // Timeout: two beats then silence.
    sendFrame();
    beat(8'($urandom), 8'($urandom));
    beat(8'($urandom), 8'($urandom));
    for (int g = 0; g < TIMEOUT; g++) idleTick();
    tick();
    checkOutput("timeout_sticky", timeout, 1);
    checkOutput("timeout_done", done, 0);
    checkReadback("timeout_rd");
    sendFrame();
    randomBeats();
    finishDone();
    checkReadback("after_timeout_rd");

    // Reset on the third give_valid cycle.
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    tick();
    tick();
    checkOutput("third_send_valid", stream.give_valid, 1);
    checkOutput("third_send_x", stream.dataX, m_px[2]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelReset();
    checkOutput("midreset_valid", stream.give_valid, 0);
    checkOutput("midreset_x", stream.dataX, 0);
    checkOutput("midreset_count", load_count, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_timeout", timeout, 0);
    checkReadback("midreset_rd");

    for (int i = 0; i < LENGTH; i++) loadPoint(8'($urandom), 8'($urandom));
    sendFrame();
    randomBeats();
    finishDone();
    checkReadback("random_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
